// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the multi-channel input debouncer: per-channel state
// encoding and threshold / counter sizing helpers.
package input_debouncer_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        STABLE_LOW  = 2'd0,
        PEND_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        PEND_LOW    = 2'd3
    } deb_state_e;

    // Stable-time threshold in clock cycles, never below one cycle.
    function automatic int unsigned debounce_threshold(input int unsigned freq_hz,
                                                       input int unsigned time_us);
        int unsigned n;
        n = (freq_hz / 32'd1000000) * time_us;
        return (n < 32'd1) ? 32'd1 : n;
    endfunction

    // One bit of headroom above clog2 so the count never wraps.
    function automatic int unsigned counter_width(input int unsigned n);
        return $unsigned($clog2(n)) + 32'd1;
    endfunction

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounce lane: 2-flop synchronizer, stable/pending FSM with a stability
// counter, registered level and one-cycle edge pulses.
module debounce_channel
    import input_debouncer_pkg::*;
#(
    parameter int unsigned THRESHOLD = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_input,
    output logic debounced,
    output logic rise,
    output logic fall
);

    localparam int unsigned CNT_W = counter_width(THRESHOLD);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(THRESHOLD - 32'd1);

    logic             sync1;
    logic             sync2;
    deb_state_e       state;
    deb_state_e       state_n;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             debounced_n;
    logic             rise_n;
    logic             fall_n;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            state     <= STABLE_LOW;
            count     <= '0;
            debounced <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync1     <= raw_input;
            sync2     <= sync1;
            state     <= state_n;
            count     <= count_n;
            debounced <= debounced_n;
            rise      <= rise_n;
            fall      <= fall_n;
        end
    end

    // A pending state needs THRESHOLD further agreeing samples before it commits.
    always_comb begin
        state_n     = state;
        count_n     = count;
        debounced_n = debounced;
        rise_n      = 1'b0;
        fall_n      = 1'b0;
        case (state)
            STABLE_LOW: begin
                if (sync2) begin
                    state_n = PEND_HIGH;
                    count_n = '0;
                end
            end
            PEND_HIGH: begin
                if (!sync2) begin
                    state_n = STABLE_LOW;
                    count_n = '0;
                end else if (count == LAST_COUNT) begin
                    state_n     = STABLE_HIGH;
                    count_n     = '0;
                    debounced_n = 1'b1;
                    rise_n      = 1'b1;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync2) begin
                    state_n = PEND_LOW;
                    count_n = '0;
                end
            end
            PEND_LOW: begin
                if (sync2) begin
                    state_n = STABLE_HIGH;
                    count_n = '0;
                end else if (count == LAST_COUNT) begin
                    state_n     = STABLE_LOW;
                    count_n     = '0;
                    debounced_n = 1'b0;
                    fall_n      = 1'b1;
                end else begin
                    count_n = count + CNT_W'(1);
                end
            end
            default: begin
                state_n     = STABLE_LOW;
                count_n     = '0;
                debounced_n = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel button/switch debouncer; each raw input gets its own
// independent synchronizer, filter and edge-pulse lane.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY  = 50000000,
    parameter int unsigned DEBOUNCE_TIME_US = 10000,
    parameter int unsigned WIDTH            = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_input,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned THRESHOLD = debounce_threshold(CLOCK_FREQUENCY, DEBOUNCE_TIME_US);

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_channel
        debounce_channel #(
            .THRESHOLD (THRESHOLD)
        ) u_channel (
            .clock     (clock),
            .reset     (reset),
            .raw_input (raw_input[i]),
            .debounced (debounced[i]),
            .rise      (rise[i]),
            .fall      (fall[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer with N=4, four channels.
module tb_input_debouncer;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] raw_input = 4'b0000;
    logic [3:0] debounced;
    logic [3:0] rise;
    logic [3:0] fall;

    int n_checks = 0;
    int n_fail   = 0;

    input_debouncer #(
        .CLOCK_FREQUENCY  (1000000),
        .DEBOUNCE_TIME_US (4),
        .WIDTH            (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .raw_input (raw_input),
        .debounced (debounced),
        .rise      (rise),
        .fall      (fall)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the filter sees raw delayed two samples; a level that disagrees
    // with the accepted level for N+1 consecutive samples becomes the new level.
    logic [3:0] dly1 = '0;
    logic [3:0] dly2 = '0;
    int         run[4];
    logic [3:0] m_deb  = '0;
    logic [3:0] m_rise = '0;
    logic [3:0] m_fall = '0;
    bit         model_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            dly1 = '0;
            dly2 = '0;
            m_deb = '0;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
            model_valid = 1'b1;
        end else begin
            logic [3:0] seen;
            seen = dly2;
            dly2 = dly1;
            dly1 = raw_input;
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_deb[i]) begin
                    run[i]++;
                    if (run[i] == N + 1) begin
                        m_deb[i] = seen[i];
                        run[i] = 0;
                        if (seen[i]) m_rise[i] = 1'b1;
                        else         m_fall[i] = 1'b1;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (model_valid) begin
            check("model_debounced", debounced, m_deb);
            check("model_rise", rise, m_rise);
            check("model_fall", fall, m_fall);
            check("rise_fall_exclusive", rise & fall, 4'b0000);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        // reset and basic acceptance on channel 0
        step(3);
        reset = 1'b0;
        check("reset_debounced", debounced, 4'b0000);
        check("reset_pulses", rise | fall, 4'b0000);
        raw_input[0] = 1'b1;
        step(6);
        check("ch0_before_edge7", debounced, 4'b0000);
        step(1);
        check("ch0_deb_edge7", debounced, 4'b0001);
        check("ch0_rise_edge7", rise, 4'b0001);
        step(1);
        check("ch0_rise_one_cycle", rise, 4'b0000);

        // 4-cycle glitch rejected, 5-cycle level accepted
        raw_input[1] = 1'b1;
        step(4);
        raw_input[1] = 1'b0;
        step(10);
        check("ch1_short_rejected", debounced, 4'b0001);
        raw_input[1] = 1'b1;
        step(5);
        raw_input[1] = 1'b0;
        step(2);
        check("ch1_long_accepted", debounced, 4'b0011);
        check("ch1_rise", rise, 4'b0010);
        step(12);
        check("ch1_back_low", debounced, 4'b0001);

        // bouncing on channel 2
        raw_input[2] = 1'b1; step(1);
        raw_input[2] = 1'b0; step(1);
        raw_input[2] = 1'b1; step(1);
        raw_input[2] = 1'b0; step(1);
        raw_input[2] = 1'b1;
        step(6);
        check("ch2_not_yet", debounced, 4'b0001);
        check("ch2_no_early_rise", rise, 4'b0000);
        step(1);
        check("ch2_deb", debounced, 4'b0101);
        check("ch2_rise", rise, 4'b0100);

        // reset while channel 3 is pending high
        raw_input[3] = 1'b1;
        step(4);
        reset = 1'b1;
        step(2);
        check("rst_mid_deb", debounced, 4'b0000);
        check("rst_mid_pulses", rise | fall, 4'b0000);
        reset = 1'b0;
        step(6);
        check("post_rst_not_yet", debounced, 4'b0000);
        step(1);
        check("post_rst_deb", debounced, 4'b1101);
        check("post_rst_rise", rise, 4'b1101);

        // all channels fall together
        raw_input[1] = 1'b1;
        step(10);
        check("all_high", debounced, 4'b1111);
        raw_input = 4'b0000;
        step(6);
        check("all_fall_not_yet", debounced, 4'b1111);
        step(1);
        check("all_fall_deb", debounced, 4'b0000);
        check("all_fall_pulse", fall, 4'b1111);
        check("all_fall_no_rise", rise, 4'b0000);
        step(1);
        check("all_fall_one_cycle", fall, 4'b0000);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter CLOCK_FREQUENCY, default 50000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter DEBOUNCE_TIME_US, default 10000, meaning the required stable time in microseconds.
REQ-003 SHALL have parameter WIDTH, default 4, meaning the number of independent input channels.
REQ-004 SHALL have port clock  input  1  single clock for all logic.
REQ-005 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port raw_input  input  WIDTH  asynchronous board buttons/switches, one per channel.
REQ-007 SHALL have port debounced  output  WIDTH  filtered stable level per channel; feeds the SoC reset and gpio_input.
REQ-008 SHALL have port rise  output  WIDTH  one-cycle pulse per channel on a debounced 0->1 transition.
REQ-009 SHALL have port fall  output  WIDTH  one-cycle pulse per channel on a debounced 1->0 transition.

Function
REQ-010 SHALL set threshold N = (CLOCK_FREQUENCY/1000000)*DEBOUNCE_TIME_US, clamped to a minimum of 1; counter width = clog2(N)+1 bits, no overflow possible.
REQ-011 SHALL pass each raw_input bit through a 2-flop synchronizer (sync1, sync2) before any use.
REQ-012 SHALL run one 4-state FSM per channel: STABLE_LOW, PEND_HIGH, STABLE_HIGH, PEND_LOW.
REQ-013 STABLE_LOW: sync2=1 -> PEND_HIGH with counter=0; else stay.
REQ-014 PEND_HIGH: sync2=0 -> STABLE_LOW with counter cleared, no output change; sync2=1 and counter<N-1 -> counter+1; sync2=1 and counter=N-1 -> STABLE_HIGH.
REQ-015 STABLE_HIGH/PEND_LOW SHALL mirror REQ-013/014 with polarities inverted.
REQ-016 SHALL update debounced registered, on the same edge as the entry into the new stable state.
REQ-017 SHALL assert rise (fall) for exactly the one cycle following a STABLE_LOW->STABLE_HIGH (STABLE_HIGH->STABLE_LOW) transition, coincident with the new debounced value.
REQ-018 Latency: a clean raw change occurring before edge k SHALL update debounced at edge k+N+2, i.e. N+3 edges including edge k.
REQ-019 A raw level held for <= N cycles SHALL be rejected; a raw level held for >= N+1 cycles SHALL be accepted.
REQ-020 Bounces during a pending state SHALL return the FSM to the prior stable state and restart the count from 0 on the next change.
REQ-021 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulses in the same cycle.
REQ-022 rise and fall SHALL never be asserted together on one channel.

Reset
REQ-023 While reset=1 at a clock edge, sync1, sync2, and counters SHALL clear to 0, every FSM SHALL go to STABLE_LOW, and debounced/rise/fall SHALL be 0.
REQ-024 Reset asserted mid-pending SHALL abort the pending transition with no pulse.
REQ-025 After reset release with raw_input held high, debounced SHALL rise via the normal path (N+3 edges) and generate a rise pulse.

Structure
REQ-026 State encodings and the threshold/counter-width computation SHALL live in a shared package input_debouncer_pkg.
REQ-027 SHALL use one sub-module, debounce_channel (synchronizer, FSM, counter, pulses), instantiated WIDTH times by generate.

Verification (CLOCK_FREQUENCY=1000000, DEBOUNCE_TIME_US=4, so N=4, WIDTH=4)
REQ-028 Reset, then raw_input[0] 0->1 before edge 1 and held -> debounced[0]=1 after edge 7, rise[0]=1 for exactly that one cycle, other channels 0.
REQ-029 raw_input[1] high for exactly 4 cycles -> debounced[1] stays 0, no pulses; repeat for 5 cycles -> debounced[1]=1 with one rise pulse.
REQ-030 raw_input[2] toggles 1,0,1,0,1 cycle-by-cycle then holds 1 -> exactly one rise, 7 edges after the final 0->1.
REQ-031 reset=1 while channel 3 is in PEND_HIGH -> no rise pulse, all outputs 0; with the input still high after release -> rise pulse after 7 edges.
REQ-032 All four channels go 1->0 from stable high in the same cycle -> fall=4'b1111 for one cycle, debounced=4'b0000, rise=4'b0000 throughout.
